// File: rtl/pulse_period_meter.sv
// Measures period and high time of an asynchronous square wave in clk cycles,
// with a one-cycle valid strobe, a lock flag and a timeout strobe on a stalled input.
module pulse_period_meter #(
    parameter int W         = 16,
    parameter int MAX_COUNT = (2 ** W) - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         locked,
    output logic         timeout
);

    localparam logic [W-1:0] MAX_C = W'(MAX_COUNT);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t       state_q, state_d;
    logic         s1_q, s1_d;
    logic         s2_q, s2_d;
    logic         s3_q, s3_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] high_time_q, high_time_d;
    logic         valid_q, valid_d;
    logic         locked_q, locked_d;
    logic         timeout_q, timeout_d;

    logic rise;
    logic fall;

    // s1/s2 form the metastability synchroniser; s3 is the edge-detect history.
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    always_comb begin
        state_d     = state_q;
        s1_d        = sig_in;
        s2_d        = s1_q;
        s3_d        = s2_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = W'(1);
                end
            end
            MEASURE: begin
                // A rise on the terminal count wins over the timeout.
                if (rise) begin
                    period_d    = cnt_q;
                    high_time_d = hi_q;
                    valid_d     = 1'b1;
                    locked_d    = 1'b1;
                    cnt_d       = W'(1);
                end else if (cnt_q == MAX_C) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + W'(1);
                    if (fall) begin
                        hi_d = cnt_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            cnt_q       <= '0;
            hi_q        <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: a W=16 and a W=8 instance share one input and are
// checked every cycle against a timestamp-based model, plus table and corner sequences.
module tb_pulse_period_meter;

    logic clk = 1'b0;
    logic rst;
    logic sig_in;

    logic [15:0] per16, hi16;
    logic        v16, l16, t16;
    logic [7:0]  per8, hi8;
    logic        v8, l8, t8;

    always #5 clk = ~clk;

    pulse_period_meter #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .sig_in(sig_in),
        .period(per16), .high_time(hi16), .valid(v16), .locked(l16), .timeout(t16)
    );

    pulse_period_meter #(.W(8), .MAX_COUNT(255)) dut8 (
        .clk(clk), .rst(rst), .sig_in(sig_in),
        .period(per8), .high_time(hi8), .valid(v8), .locked(l8), .timeout(t8)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Inputs as seen at the most recent posedge.
    logic samp_sig = 1'b0;
    logic samp_rst = 1'b1;
    always @(posedge clk) begin
        samp_sig <= sig_in;
        samp_rst <= rst;
    end

    // Model: input transitions become timestamped events two edges later;
    // measurements are differences between event timestamps.
    int   ev_t[$];
    logic ev_v[$];
    logic m_prev = 1'b0;
    int   max_c[2] = '{65535, 255};
    int   m_armed[2], m_last[2], m_hi[2], m_per[2], m_high[2];
    int   m_locked[2], m_valid[2], m_to[2];

    // Observed statistics, consumed by the directed sequences.
    int v_cnt[2]    = '{0, 0};
    int to_cnt[2]   = '{0, 0};
    int to_cyc[2]   = '{0, 0};
    int last_per[2] = '{0, 0};
    int last_hi[2]  = '{0, 0};

    task automatic model_step();
        logic r, f;
        int   el;
        r = 1'b0;
        f = 1'b0;
        if (samp_rst) begin
            ev_t.delete();
            ev_v.delete();
            m_prev = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_armed[d] = 0; m_last[d] = 0; m_hi[d] = 0; m_per[d] = 0;
                m_high[d] = 0; m_locked[d] = 0; m_valid[d] = 0; m_to[d] = 0;
            end
        end else begin
            if (ev_t.size() > 0 && ev_t[0] == cyc) begin
                r = ev_v[0];
                f = ~ev_v[0];
                void'(ev_t.pop_front());
                void'(ev_v.pop_front());
            end
            if (samp_sig != m_prev) begin
                ev_t.push_back(cyc + 2);
                ev_v.push_back(samp_sig);
                m_prev = samp_sig;
            end
            for (int d = 0; d < 2; d++) begin
                m_valid[d] = 0;
                m_to[d]    = 0;
                if (m_armed[d] == 0) begin
                    if (r) begin
                        m_armed[d] = 1;
                        m_last[d]  = cyc;
                    end
                end else begin
                    el = cyc - m_last[d];
                    if (r) begin
                        m_per[d]    = el;
                        m_high[d]   = m_hi[d];
                        m_valid[d]  = 1;
                        m_locked[d] = 1;
                        m_last[d]   = cyc;
                    end else if (el == max_c[d]) begin
                        m_to[d]     = 1;
                        m_locked[d] = 0;
                        m_armed[d]  = 0;
                    end else if (f) begin
                        m_hi[d] = el;
                    end
                end
            end
        end
    endtask

    task automatic get_out(input int d, output int p, output int h, output int v,
                           output int l, output int t);
        if (d == 0) begin
            p = int'(per16); h = int'(hi16); v = int'(v16); l = int'(l16); t = int'(t16);
        end else begin
            p = int'(per8); h = int'(hi8); v = int'(v8); l = int'(l8); t = int'(t8);
        end
    endtask

    initial begin
        int p, h, v, l, t;
        forever begin
            @(negedge clk);
            cyc++;
            model_step();
            for (int d = 0; d < 2; d++) begin
                get_out(d, p, h, v, l, t);
                tests++;
                if (p != m_per[d] || h != m_high[d] || v != m_valid[d] ||
                    l != m_locked[d] || t != m_to[d]) begin
                    fails++;
                    $display("FAIL model_w%0d cyc %0d: got per=%0d hi=%0d v=%0d l=%0d t=%0d, expected per=%0d hi=%0d v=%0d l=%0d t=%0d",
                             (d == 0) ? 16 : 8, cyc, p, h, v, l, t,
                             m_per[d], m_high[d], m_valid[d], m_locked[d], m_to[d]);
                end
                if (v == 1) begin
                    v_cnt[d]++;
                    last_per[d] = p;
                    last_hi[d]  = h;
                end
                if (t == 1) begin
                    to_cnt[d]++;
                    to_cyc[d] = cyc;
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the falling edge, after the checker has run.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input logic lvl, input int n);
        sig_in = lvl;
        repeat (n) tick();
    endtask

    task automatic seg(input int per, input int hi, input int reps);
        repeat (reps) begin
            hold(1'b1, hi);
            hold(1'b0, per - hi);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_per16"}, int'(per16), 0);
        check({tag, "_hi16"}, int'(hi16), 0);
        check({tag, "_v16"}, int'(v16), 0);
        check({tag, "_l16"}, int'(l16), 0);
        check({tag, "_t16"}, int'(t16), 0);
        check({tag, "_per8"}, int'(per8), 0);
        check({tag, "_l8"}, int'(l8), 0);
        check({tag, "_t8"}, int'(t8), 0);
    endtask

    typedef struct {
        int per;
        int hi;
        int reps;
        int exp_per;
        int exp_hi;
        int exp_nvalid;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int   v0, t0, d0, per, hi, reps;

        vecs[0] = '{per: 1500, hi: 750, reps: 3, exp_per: 1500, exp_hi: 750, exp_nvalid: 2};
        vecs[1] = '{per: 10,   hi: 3,   reps: 4, exp_per: 10,   exp_hi: 3,   exp_nvalid: 4};
        vecs[2] = '{per: 37,   hi: 20,  reps: 3, exp_per: 37,   exp_hi: 20,  exp_nvalid: 3};
        vecs[3] = '{per: 2,    hi: 1,   reps: 5, exp_per: 2,    exp_hi: 1,   exp_nvalid: 5};

        // Reset held for three cycles while the input toggles.
        rst    = 1'b1;
        sig_in = 1'b0;
        tick();
        repeat (3) begin
            sig_in = ~sig_in;
            tick();
        end
        check_cleared("reset");
        rst = 1'b0;
        hold(1'b0, 4);

        // Nominal rate, then rate/duty changes.
        for (int i = 0; i < 4; i++) begin
            v0 = v_cnt[0];
            seg(vecs[i].per, vecs[i].hi, vecs[i].reps);
            hold(1'b0, 4);
            check($sformatf("vec%0d_nvalid", i), v_cnt[0] - v0, vecs[i].exp_nvalid);
            check($sformatf("vec%0d_period", i), last_per[0], vecs[i].exp_per);
            check($sformatf("vec%0d_high", i), last_hi[0], vecs[i].exp_hi);
            check($sformatf("vec%0d_locked", i), int'(l16), 1);
        end

        // Random waveforms.
        for (int r = 0; r < 6; r++) begin
            per  = $urandom_range(400, 2);
            hi   = $urandom_range(per - 1, 1);
            reps = $urandom_range(4, 2);
            seg(per, hi, reps);
            hold(1'b0, 4);
            check($sformatf("rand%0d_period", r), last_per[0], per);
            check($sformatf("rand%0d_high", r), last_hi[0], hi);
        end

        // Timeout on the 8-bit instance: stop toggling after a rise.
        seg(100, 50, 3);
        t0 = to_cnt[1];
        d0 = cyc;
        hold(1'b1, 5);
        hold(1'b0, 300);
        check("to_count", to_cnt[1] - t0, 1);
        check("to_cycle", to_cyc[1], d0 + 258);
        check("to_period_kept", int'(per8), 100);
        check("to_locked", int'(l8), 0);
        check("to_strobe_low", int'(t8), 0);
        v0 = v_cnt[1];
        hold(1'b1, 5);
        hold(1'b0, 20);
        check("rearm_no_valid", v_cnt[1] - v0, 0);
        hold(1'b1, 5);
        hold(1'b0, 300);
        check("rearm_valid", v_cnt[1] - v0, 1);
        check("rearm_period", last_per[1], 25);
        check("rearm_high", last_hi[1], 5);

        // Rises exactly MAX_COUNT apart on the 8-bit instance.
        t0 = to_cnt[1];
        v0 = v_cnt[1];
        seg(255, 100, 3);
        check("bound_no_timeout", to_cnt[1] - t0, 0);
        check("bound_nvalid", v_cnt[1] - v0, 2);
        check("bound_period", last_per[1], 255);
        check("bound_high", last_hi[1], 100);
        check("bound_locked", int'(l8), 1);

        // Reset 600 cycles into a 1500-cycle period, input still high at release.
        hold(1'b1, 600);
        rst = 1'b1;
        tick();
        check_cleared("midrst");
        rst = 1'b0;
        v0  = v_cnt[0];
        hold(1'b1, 150);
        hold(1'b0, 750);
        seg(1500, 750, 2);
        check("midrst_nvalid", v_cnt[0] - v0, 2);
        check("midrst_period", last_per[0], 1500);
        check("midrst_high", last_hi[0], 750);
        check("midrst_locked", int'(l16), 1);

        hold(1'b0, 10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
